// File: rtl/mem_byte_sequencer.sv
// Byte-serial memory sequencer: splits byte/halfword/word requests
// into big-endian single-byte cycles on an 8-bit RAM port.
module mem_byte_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        typeData,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              ERR,
    output logic              BUSY,
    output logic [ADDR_W-1:0] BADDR,
    output logic [7:0]        BWDATA,
    input  logic [7:0]        BRDATA,
    output logic              BRE,
    output logic              BWE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAP,
        S_DONE
    } state_t;

    localparam logic [3:0] WLAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t            state, state_d;
    logic [2:0]        idx, idx_d;
    logic [2:0]        nbytes, nbytes_d;
    logic [3:0]        wcnt, wcnt_d;
    logic              rd, rd_d;
    logic [ADDR_W-1:0] base, base_d;
    logic [31:0]       wdata, wdata_d;

    logic [31:0]       dout_d;
    logic              moc_d, err_d, busy_d, bre_d, bwe_d;
    logic [ADDR_W-1:0] baddr_d;
    logic [7:0]        bwdata_d;

    logic              illegal;
    logic [2:0]        req_n;
    logic [2:0]        nxt;

    // Byte k of the right-justified write field (k=0 is the LSB)
    function automatic logic [7:0] pick(input logic [31:0] d, input logic [1:0] k);
        return d[{k, 3'b000} +: 8];
    endfunction

    always_comb begin
        unique case (typeData)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            2'b10:   req_n = 3'd4;
            default: req_n = 3'd1;
        endcase
        illegal = (typeData == 2'b11)
                | ((typeData == 2'b01) & Addr[0])
                | ((typeData == 2'b10) & (Addr[1:0] != 2'b00));
    end

    assign nxt = idx + 3'd1;

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        nbytes_d = nbytes;
        wcnt_d   = wcnt;
        rd_d     = rd;
        base_d   = base;
        wdata_d  = wdata;
        dout_d   = DataOut;
        moc_d    = MOC;
        err_d    = ERR;
        busy_d   = BUSY;
        baddr_d  = BADDR;
        bwdata_d = BWDATA;
        bre_d    = 1'b0;
        bwe_d    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (MOV) begin
                    rd_d     = RW;
                    base_d   = Addr;
                    wdata_d  = DataIn;
                    nbytes_d = req_n;
                    busy_d   = 1'b1;
                    if (illegal) begin
                        state_d = S_DONE;
                        moc_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_REQ;
                        idx_d    = 3'd0;
                        dout_d   = 32'd0;
                        baddr_d  = Addr;
                        bwdata_d = pick(DataIn, 2'(req_n - 3'd1));
                        bre_d    = RW;
                        bwe_d    = ~RW;
                    end
                end
            end
            S_REQ: begin
                wcnt_d  = 4'd0;
                state_d = (WAIT_STATES == 0) ? S_CAP : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == WLAST) state_d = S_CAP;
                else               wcnt_d  = wcnt + 4'd1;
            end
            S_CAP: begin
                if (rd) dout_d = {DataOut[23:0], BRDATA};
                idx_d = nxt;
                if (nxt < nbytes) begin
                    state_d  = S_REQ;
                    baddr_d  = base + ADDR_W'(nxt);
                    bwdata_d = pick(wdata, 2'(nbytes - 3'd1 - nxt));
                    bre_d    = rd;
                    bwe_d    = ~rd;
                end else begin
                    state_d = S_DONE;
                    moc_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= S_IDLE;
            idx     <= 3'd0;
            nbytes  <= 3'd0;
            wcnt    <= 4'd0;
            rd      <= 1'b0;
            base    <= '0;
            wdata   <= 32'd0;
            DataOut <= 32'd0;
            MOC     <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            BADDR   <= '0;
            BWDATA  <= 8'd0;
            BRE     <= 1'b0;
            BWE     <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            nbytes  <= nbytes_d;
            wcnt    <= wcnt_d;
            rd      <= rd_d;
            base    <= base_d;
            wdata   <= wdata_d;
            DataOut <= dout_d;
            MOC     <= moc_d;
            ERR     <= err_d;
            BUSY    <= busy_d;
            BADDR   <= baddr_d;
            BWDATA  <= bwdata_d;
            BRE     <= bre_d;
            BWE     <= bwe_d;
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer: two instances (0 and 2 wait
// states) on behavioural 256x8 RAMs, strobes checked from a queue.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        ram_init;
    logic        mov      [2];
    logic        rw       [2];
    logic [1:0]  ty       [2];
    logic [7:0]  addr     [2];
    logic [31:0] din      [2];
    logic [31:0] dout     [2];
    logic        moc      [2];
    logic        err      [2];
    logic        busy     [2];
    logic [7:0]  baddr    [2];
    logic [7:0]  bwdata   [2];
    logic [7:0]  brdata   [2];
    logic        bre      [2];
    logic        bwe      [2];
    logic [7:0]  ram      [2][256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        int         e;
    } stb_t;

    typedef struct packed {
        logic [31:0] d;
        bit          err;
        int          e;
    } res_t;

    stb_t sq[$];
    res_t rq[$];

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(8), .WAIT_STATES(0)) u0 (
        .CLK(clk), .CLR(clr), .MOV(mov[0]), .RW(rw[0]),
        .typeData(ty[0]), .Addr(addr[0]), .DataIn(din[0]),
        .DataOut(dout[0]), .MOC(moc[0]), .ERR(err[0]), .BUSY(busy[0]),
        .BADDR(baddr[0]), .BWDATA(bwdata[0]), .BRDATA(brdata[0]),
        .BRE(bre[0]), .BWE(bwe[0])
    );

    mem_byte_sequencer #(.ADDR_W(8), .WAIT_STATES(2)) u2 (
        .CLK(clk), .CLR(clr), .MOV(mov[1]), .RW(rw[1]),
        .typeData(ty[1]), .Addr(addr[1]), .DataIn(din[1]),
        .DataOut(dout[1]), .MOC(moc[1]), .ERR(err[1]), .BUSY(busy[1]),
        .BADDR(baddr[1]), .BWDATA(bwdata[1]), .BRDATA(brdata[1]),
        .BRE(bre[1]), .BWE(bwe[1])
    );

    // RAM model: read data appears the cycle after BRE
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ram_init) begin
                for (int j = 0; j < 256; j++) ram[u][j] = 8'h00;
                ram[u][8'h10] = 8'hDE;
                ram[u][8'h11] = 8'hAD;
                ram[u][8'h12] = 8'hBE;
                ram[u][8'h13] = 8'hEF;
                brdata[u] <= 8'h00;
            end else begin
                if (bwe[u]) ram[u][baddr[u]] = bwdata[u];
                if (bre[u]) brdata[u] <= ram[u][baddr[u]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int u, input string tag);
        check({tag, "_dout"},   dout[u],   32'd0);
        check({tag, "_moc"},    32'(moc[u]),    32'd0);
        check({tag, "_err"},    32'(err[u]),    32'd0);
        check({tag, "_busy"},   32'(busy[u]),   32'd0);
        check({tag, "_baddr"},  32'(baddr[u]),  32'd0);
        check({tag, "_bwdata"}, 32'(bwdata[u]), 32'd0);
        check({tag, "_bre"},    32'(bre[u]),    32'd0);
        check({tag, "_bwe"},    32'(bwe[u]),    32'd0);
    endtask

    task automatic run(input int u, input logic r, input logic [1:0] t,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_do, input bit exp_err,
                       input bit drop);
        int     n, w, e;
        bit     done;
        stb_t   s, g;
        res_t   res;
        logic [31:0] tmp;
        n = (t == 2'b10) ? 4 : (t == 2'b01) ? 2 : 1;
        w = (u == 1) ? 2 : 0;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                tmp  = d >> (8 * (n - 1 - i));
                s.wr = !r;
                s.a  = a + 8'(i);
                s.d  = r ? 8'h00 : tmp[7:0];
                s.e  = i * (2 + w);
                sq.push_back(s);
            end
        end
        res.d   = exp_do;
        res.err = exp_err;
        res.e   = exp_err ? 0 : n * (2 + w);
        rq.push_back(res);

        @(negedge clk);
        mov[u] = 1'b1; rw[u] = r; ty[u] = t; addr[u] = a; din[u] = d;
        done = 0;
        e = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            e = k;
            if (k == 0 && drop) mov[u] = 1'b0;
            if (k == 0) begin
                ty[u] = 2'b11; addr[u] = 8'hFF; din[u] = 32'h0;
            end
            if (bre[u] || bwe[u]) begin
                if (sq.size() == 0) begin
                    check("extra_strobe", 32'd1, 32'd0);
                end else begin
                    g = sq.pop_front();
                    check("strobe_kind", {bre[u], bwe[u]}, {!g.wr, g.wr});
                    check("strobe_addr", 32'(baddr[u]), 32'(g.a));
                    if (g.wr) check("strobe_data", 32'(bwdata[u]), 32'(g.d));
                    check("strobe_edge", 32'(k), 32'(g.e));
                end
            end
            if (moc[u]) done = 1;
        end
        res = rq.pop_front();
        if (!done) begin
            check("moc_timeout", 32'd0, 32'd1);
        end else begin
            check("moc_edge", 32'(e), 32'(res.e));
            check("dataout",  dout[u], res.d);
            check("err",      32'(err[u]), 32'(res.err));
            check("busy_done", 32'(busy[u]), 32'd1);
        end
        check("strobes_left", 32'(sq.size()), 32'd0);
        sq.delete();
        if (!drop) begin
            @(negedge clk);
            check("moc_hold", 32'(moc[u]), 32'd1);
            mov[u] = 1'b0;
        end
        @(negedge clk);
        check("moc_clear",  32'(moc[u]),  32'd0);
        check("err_clear",  32'(err[u]),  32'd0);
        check("busy_clear", 32'(busy[u]), 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            mov[u] = 1'b0; rw[u] = 1'b0; ty[u] = 2'b00;
            addr[u] = 8'h00; din[u] = 32'h0;
        end
        clr = 1'b1;
        ram_init = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst2");
        ram_init = 1'b0;
        clr = 1'b0;
        @(negedge clk);

        run(0, 1'b1, 2'b10, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        run(0, 1'b1, 2'b01, 8'h12, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        run(0, 1'b1, 2'b10, 8'h11, 32'h0, 32'h0000BEEF, 1'b1, 1'b0);
        run(0, 1'b1, 2'b11, 8'h00, 32'h0, 32'h0000BEEF, 1'b1, 1'b0);
        run(0, 1'b0, 2'b01, 8'h13, 32'h1234, 32'h0000BEEF, 1'b1, 1'b0);
        run(0, 1'b1, 2'b00, 8'h13, 32'h0, 32'h000000EF, 1'b0, 1'b1);

        run(0, 1'b0, 2'b00, 8'h05, 32'h123456AA, 32'h0, 1'b0, 1'b0);
        check("ram05", 32'(ram[0][8'h05]), 32'hAA);
        check("ram04", 32'(ram[0][8'h04]), 32'h00);
        check("ram06", 32'(ram[0][8'h06]), 32'h00);

        run(1, 1'b0, 2'b10, 8'h20, 32'hCAFEBABE, 32'h0, 1'b0, 1'b0);
        check("w2_ram20", 32'(ram[1][8'h20]), 32'hCA);
        check("w2_ram21", 32'(ram[1][8'h21]), 32'hFE);
        check("w2_ram22", 32'(ram[1][8'h22]), 32'hBA);
        check("w2_ram23", 32'(ram[1][8'h23]), 32'hBE);

        // CLR lands after the second byte has been written
        @(negedge clk);
        mov[0] = 1'b1; rw[0] = 1'b0; ty[0] = 2'b10;
        addr[0] = 8'h20; din[0] = 32'hCAFEBABE;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        #1;
        check_idle_outputs(0, "clr");
        mov[0] = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_bwe", 32'(bwe[0]), 32'd0);
        check("clr_ram20", 32'(ram[0][8'h20]), 32'hCA);
        check("clr_ram21", 32'(ram[0][8'h21]), 32'hFE);
        check("clr_ram22", 32'(ram[0][8'h22]), 32'h00);
        check("clr_ram23", 32'(ram[0][8'h23]), 32'h00);

        run(0, 1'b1, 2'b01, 8'h12, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
